// File: rtl/gmii_rx_framer_pkg.sv
// Shared definitions for the GMII receive framer and the CRC-32 datapath.
package gmii_rx_framer_pkg;

  typedef enum logic [1:0] {
    ST_DROP     = 2'd0,
    ST_IDLE     = 2'd1,
    ST_PREAMBLE = 2'd2,
    ST_DATA     = 2'd3
  } rx_state_e;

  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [7:0]  SFD           = 8'hD5;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;

  localparam int unsigned LEN_W     = 11;
  localparam int unsigned DLY_DEPTH = 4;
  localparam logic [LEN_W-1:0] LEN_SAT = '1;

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide reflected IEEE 802.3 CRC-32 next-state function (no init, no final inversion).
module crc32_d8
  import gmii_rx_framer_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  logic [31:0] w_c;

  // LSB-first: fold the byte into the low bits, then shift out 8 bits.
  always_comb begin
    w_c = i_crc ^ {24'h0, i_data};
    for (int i = 0; i < 8; i++) begin
      w_c = w_c[0] ? ((w_c >> 1) ^ CRC_POLY) : (w_c >> 1);
    end
    o_crc = w_c;
  end

endmodule

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD and FCS, checks CRC and length, counts frames.
module gmii_rx_framer
  import gmii_rx_framer_pkg::*;
#(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rx_dv,
  input  logic [7:0]  rx_data,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_sof,
  output logic        out_end,
  output logic        out_crc_ok,
  output logic        out_len_err,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  rx_state_e                       r_state, w_state;
  logic [31:0]                     r_crc, w_crc, w_crc_nxt;
  logic [LEN_W-1:0]                r_len, w_len;
  logic [DLY_DEPTH-1:0][7:0]       r_dly, w_dly;
  logic                            w_valid, w_sof, w_end, w_crc_ok, w_len_err;
  logic [7:0]                      w_data;
  logic [15:0]                     w_good, w_bad;
  logic                            w_len_bad, w_frame_ok;

  crc32_d8 u_crc (
    .i_crc  (r_crc),
    .i_data (rx_data),
    .o_crc  (w_crc_nxt)
  );

  // State, datapath and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_DROP;
      r_crc       <= '0;
      r_len       <= '0;
      r_dly       <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sof     <= 1'b0;
      out_end     <= 1'b0;
      out_crc_ok  <= 1'b0;
      out_len_err <= 1'b0;
      good_cnt    <= '0;
      bad_cnt     <= '0;
    end else begin
      r_state     <= w_state;
      r_crc       <= w_crc;
      r_len       <= w_len;
      r_dly       <= w_dly;
      out_valid   <= w_valid;
      out_data    <= w_data;
      out_sof     <= w_sof;
      out_end     <= w_end;
      out_crc_ok  <= w_crc_ok;
      out_len_err <= w_len_err;
      good_cnt    <= w_good;
      bad_cnt     <= w_bad;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state    = r_state;
    w_crc      = r_crc;
    w_len      = r_len;
    w_dly      = r_dly;
    w_valid    = 1'b0;
    w_data     = out_data;
    w_sof      = 1'b0;
    w_end      = 1'b0;
    w_crc_ok   = 1'b0;
    w_len_err  = 1'b0;
    w_good     = good_cnt;
    w_bad      = bad_cnt;
    w_len_bad  = (32'(r_len) < MIN_LEN) || (32'(r_len) > MAX_LEN);
    w_frame_ok = (r_crc == CRC_RESIDUE) && !w_len_bad;

    case (r_state)
      ST_DROP: begin
        if (!rx_dv) w_state = ST_IDLE;
      end
      ST_IDLE, ST_PREAMBLE: begin
        if (!rx_dv) begin
          w_state = ST_IDLE;
        end else if (rx_data == PREAMBLE_BYTE) begin
          w_state = ST_PREAMBLE;
        end else if (rx_data == SFD) begin
          w_state = ST_DATA;
          w_crc   = CRC_INIT;
          w_len   = '0;
          w_dly   = '0;
        end else begin
          w_state = ST_DROP;
        end
      end
      ST_DATA: begin
        if (rx_dv) begin
          w_crc = w_crc_nxt;
          w_len = (r_len == LEN_SAT) ? r_len : r_len + LEN_W'(1);
          w_dly = {r_dly[DLY_DEPTH-2:0], rx_data};
          // The oldest delay-line byte is released only once four newer bytes exist,
          // so the trailing FCS never leaves the delay line.
          if (r_len >= LEN_W'(DLY_DEPTH)) begin
            w_valid = 1'b1;
            w_data  = r_dly[DLY_DEPTH-1];
            w_sof   = (r_len == LEN_W'(DLY_DEPTH));
          end
        end else begin
          w_end     = 1'b1;
          w_crc_ok  = (r_crc == CRC_RESIDUE);
          w_len_err = w_len_bad;
          if (w_frame_ok) w_good = good_cnt + 16'd1;
          else            w_bad  = bad_cnt + 16'd1;
          w_state = ST_IDLE;
        end
      end
      default: w_state = ST_DROP;
    endcase
  end

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Self-checking bench for gmii_rx_framer: vector table, hand sequences, random frames vs. model.
module tb_gmii_rx_framer;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        rx_dv;
  logic [7:0]  rx_data;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sof;
  logic        out_end;
  logic        out_crc_ok;
  logic        out_len_err;
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;

  gmii_rx_framer #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx_dv       (rx_dv),
    .rx_data     (rx_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_sof     (out_sof),
    .out_end     (out_end),
    .out_crc_ok  (out_crc_ok),
    .out_len_err (out_len_err),
    .good_cnt    (good_cnt),
    .bad_cnt     (bad_cnt)
  );

  always #4 clock = ~clock;

  typedef struct {
    int pre;
    bit bad_pre;
    bit arp;
    int len;
    bit flip;
    int exp_n;
    bit exp_end;
    bit exp_ok;
    bit exp_lerr;
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_ovl    = 0;
  int          cyc      = 0;
  logic [15:0] exp_good = '0;
  logic [15:0] exp_bad  = '0;
  logic [7:0]  frame[$];
  logic [7:0]  q_b[$];
  bit          q_s[$];
  bit          q_eok[$];
  bit          q_elerr[$];
  int          q_sofc[$];
  int          q_endc[$];

  // Output monitor, sampled on the falling edge.
  always @(negedge clock) begin
    cyc++;
    if (out_valid) begin
      q_b.push_back(out_data);
      q_s.push_back(out_sof);
      if (out_sof) q_sofc.push_back(cyc);
    end
    if (out_end) begin
      q_eok.push_back(out_crc_ok);
      q_elerr.push_back(out_len_err);
      q_endc.push_back(cyc);
    end
    if (out_valid && out_end) n_ovl++;
  end

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Bit-serial LFSR form of the 802.3 CRC over the LSB-first bit stream.
  function automatic logic [31:0] crc_bytes(input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    logic        fb;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 8; i++) begin
        fb = c[0] ^ frame[k][i];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return c;
  endfunction

  task automatic append_fcs();
    logic [31:0] fcs;
    fcs = ~crc_bytes(frame.size());
    for (int i = 0; i < 4; i++) frame.push_back(fcs[8*i +: 8]);
  endtask

  task automatic build_rand(input int len);
    frame = {};
    if (len >= 4) begin
      for (int i = 0; i < len - 4; i++) frame.push_back(8'($urandom));
      append_fcs();
    end else begin
      for (int i = 0; i < len; i++) frame.push_back(8'($urandom));
    end
  endtask

  task automatic build_arp();
    logic [7:0] hdr[42];
    hdr = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
            8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h08, 8'h06,
            8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
            8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h01, 8'h0A,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC0, 8'hA8, 8'h01, 8'h01};
    frame = {};
    for (int i = 0; i < 42; i++) frame.push_back(hdr[i]);
    for (int i = 0; i < 18; i++) frame.push_back(8'h00);
    append_fcs();
  endtask

  // Model: FCS match of the received trailer against the body's CRC.
  function automatic bit model_ok();
    int          n;
    logic [31:0] fcs;
    n = frame.size();
    if (n < 4) return (crc_bytes(n) == 32'hDEBB20E3);
    fcs = ~crc_bytes(n - 4);
    return {frame[n-1], frame[n-2], frame[n-3], frame[n-4]} == fcs;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_data = b;
    tick();
  endtask

  task automatic drive_frame(input int pre, input bit bad_pre, input int gap);
    if (bad_pre) begin
      send_byte(8'h55);
      send_byte(8'h54);
    end else begin
      for (int i = 0; i < pre; i++) send_byte(8'h55);
    end
    send_byte(8'hD5);
    foreach (frame[i]) send_byte(frame[i]);
    rx_dv   = 1'b0;
    rx_data = 8'h00;
    for (int i = 0; i < gap; i++) tick();
  endtask

  task automatic do_frame(input string tag, input int pre, input bit bad_pre, input int exp_n,
                          input bit exp_end, input bit exp_ok, input bit exp_lerr);
    int mb, me, nb, ne, mism, sofbad;
    mb = q_b.size();
    me = q_eok.size();
    drive_frame(pre, bad_pre, 6);
    nb = q_b.size() - mb;
    ne = q_eok.size() - me;
    chk({tag, " nbytes"}, nb, exp_n);
    mism   = 0;
    sofbad = 0;
    for (int i = 0; i < nb && i < frame.size(); i++) begin
      if (q_b[mb+i] != frame[i]) mism++;
      if (q_s[mb+i] != (i == 0)) sofbad++;
    end
    chk({tag, " data_mismatches"}, mism, 0);
    chk({tag, " sof_errors"}, sofbad, 0);
    chk({tag, " nend"}, ne, int'(exp_end));
    if (exp_end && ne > 0) begin
      chk({tag, " crc_ok"}, int'(q_eok[me]), int'(exp_ok));
      chk({tag, " len_err"}, int'(q_elerr[me]), int'(exp_lerr));
    end
    if (exp_end) begin
      if (exp_ok && !exp_lerr) exp_good++;
      else                     exp_bad++;
    end
    chk({tag, " good_cnt"}, int'(good_cnt), int'(exp_good));
    chk({tag, " bad_cnt"}, int'(bad_cnt), int'(exp_bad));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " out_valid"}, int'(out_valid), 0);
    chk({tag, " out_data"}, int'(out_data), 0);
    chk({tag, " out_sof"}, int'(out_sof), 0);
    chk({tag, " out_end"}, int'(out_end), 0);
    chk({tag, " out_crc_ok"}, int'(out_crc_ok), 0);
    chk({tag, " out_len_err"}, int'(out_len_err), 0);
    chk({tag, " good_cnt"}, int'(good_cnt), 0);
    chk({tag, " bad_cnt"}, int'(bad_cnt), 0);
  endtask

  vec_t vecs[9];

  initial begin
    int mb, me, ms, mv, len, pre;
    bit bad_pre;

    //              pre bad arp len   flip exp_n end ok lerr
    vecs[0] = '{7, 0, 1, 64,   0, 60,   1, 1, 0};
    vecs[1] = '{7, 0, 1, 64,   1, 60,   1, 0, 0};
    vecs[2] = '{0, 1, 0, 20,   0, 0,    0, 0, 0};
    vecs[3] = '{7, 0, 0, 40,   0, 36,   1, 1, 1};
    vecs[4] = '{0, 0, 0, 63,   0, 59,   1, 1, 1};
    vecs[5] = '{3, 0, 0, 1518, 0, 1514, 1, 1, 0};
    vecs[6] = '{1, 0, 0, 1519, 0, 1515, 1, 1, 1};
    vecs[7] = '{7, 0, 0, 4,    0, 0,    1, 1, 1};
    vecs[8] = '{2, 0, 0, 5,    1, 1,    1, 0, 1};

    reset_n = 1'b0;
    rx_dv   = 1'b0;
    rx_data = 8'h00;
    tick();
    tick();
    chk_outputs_zero("reset");
    reset_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      if (vecs[i].arp) build_arp();
      else             build_rand(vecs[i].len);
      if (vecs[i].flip) frame[vecs[i].len > 30 ? 30 : 0] ^= 8'h08;
      mb = q_b.size();
      do_frame($sformatf("vec%0d", i), vecs[i].pre, vecs[i].bad_pre, vecs[i].exp_n,
               vecs[i].exp_end, vecs[i].exp_ok, vecs[i].exp_lerr);
      if (vecs[i].arp) begin
        chk($sformatf("vec%0d byte0", i), int'(q_b[mb]), 8'hFF);
        chk($sformatf("vec%0d byte5", i), int'(q_b[mb+5]), 8'hFF);
      end
    end

    // Reset at frame byte 30, released while rx_dv is still high.
    build_rand(64);
    for (int i = 0; i < 7; i++) send_byte(8'h55);
    send_byte(8'hD5);
    for (int i = 0; i < 30; i++) send_byte(frame[i]);
    me = q_eok.size();
    rx_dv   = 1'b1;
    rx_data = frame[30];
    reset_n = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    mb = q_b.size();
    tick();
    send_byte(frame[31]);
    reset_n = 1'b1;
    for (int i = 32; i < 50; i++) send_byte(frame[i]);
    rx_dv = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("midreset bytes_after", q_b.size() - mb, 0);
    chk("midreset ends", q_eok.size() - me, 0);
    exp_good = '0;
    exp_bad  = '0;
    chk("midreset good_cnt", int'(good_cnt), 0);
    build_rand(64);
    do_frame("post_reset", 7, 0, 60, 1, 1, 0);

    // Back-to-back good frames with a single idle cycle.
    ms = q_sofc.size();
    me = q_endc.size();
    mv = n_ovl;
    build_rand(64);
    drive_frame(7, 0, 1);
    build_rand(64);
    drive_frame(7, 0, 6);
    exp_good += 16'd2;
    chk("b2b sofs", q_sofc.size() - ms, 2);
    chk("b2b ends", q_endc.size() - me, 2);
    if (q_endc.size() - me >= 2 && q_sofc.size() - ms >= 2) begin
      chk("b2b end_before_sof", int'(q_endc[me] < q_sofc[ms+1]), 1);
      chk("b2b crc_ok0", int'(q_eok[me]), 1);
      chk("b2b crc_ok1", int'(q_eok[me+1]), 1);
    end
    chk("b2b good_cnt", int'(good_cnt), int'(exp_good));
    chk("b2b overlap", n_ovl - mv, 0);

    // Randomized frames checked against the frame-level model.
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 9))
        0:       len = MAX_LEN - 1 + int'($urandom_range(0, 3));
        1:       len = int'($urandom_range(4, 6));
        default: len = int'($urandom_range(5, 130));
      endcase
      pre     = int'($urandom_range(0, 8));
      bad_pre = ($urandom_range(0, 9) == 0);
      build_rand(len);
      if ($urandom_range(0, 2) == 0) frame[$urandom_range(0, len - 1)] ^= 8'(1 << $urandom_range(0, 7));
      do_frame($sformatf("rand%0d", t), pre, bad_pre,
               bad_pre ? 0 : (len > 4 ? len - 4 : 0), !bad_pre, model_ok(),
               (len < MIN_LEN) || (len > MAX_LEN));
    end

    chk("overlap_total", n_ovl, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
